// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage registers.
// Default payload widths per stage boundary and the reset PC.
package pipe_pkg;

  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 160;
  localparam int EX_MEM_W = 112;
  localparam int MEM_WB_W = 72;

  localparam logic [31:0] RESET_PC = 32'h1000_0000;

endpackage

// File: rtl/pipe_slot.sv
// One payload register with valid bit.
// Clear returns the payload to RESET_VALUE and wins over load.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_q
);

  logic             r_valid;
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_q     <= RESET_VALUE;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_q     <= RESET_VALUE;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_q     <= i_d;
    end
  end

  assign o_valid = r_valid;
  assign o_q     = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with optional skid entry,
// synchronous flush and a saturating back-pressure counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               SKID        = 1,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             stall_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_main_load;
  logic             w_main_clr;
  logic [WIDTH-1:0] w_main_d;
  logic             w_main_valid;
  logic [WIDTH-1:0] w_main_q;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_in_xfer  = s_valid & s_ready & ~flush;
  assign w_out_xfer = w_main_valid & m_ready;

  pipe_slot #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_main_load),
    .i_clr   (w_main_clr),
    .i_d     (w_main_d),
    .o_valid (w_main_valid),
    .o_q     (w_main_q)
  );

  if (SKID == 0) begin : g_single
    assign s_ready     = ~w_main_valid | m_ready;
    assign w_main_load = w_in_xfer;
    assign w_main_clr  = flush | (w_out_xfer & ~w_in_xfer);
    assign w_main_d    = s_data;
  end else begin : g_skid
    logic             w_skid_load;
    logic             w_skid_clr;
    logic             w_skid_valid;
    logic [WIDTH-1:0] w_skid_q;
    logic             w_skid_mv;
    logic             w_main_take;
    logic             w_skid_nxt;
    logic             r_s_ready;

    // s_ready is low whenever skid is full, so skid refill and
    // direct input loads into main never coincide.
    assign w_skid_mv   = w_skid_valid & w_out_xfer;
    assign w_main_take = w_in_xfer & (~w_main_valid | m_ready);
    assign w_main_load = w_skid_mv | w_main_take;
    assign w_main_d    = w_skid_valid ? w_skid_q : s_data;
    assign w_main_clr  = flush | (w_out_xfer & ~w_main_load);

    assign w_skid_load = w_in_xfer & w_main_valid & ~m_ready;
    assign w_skid_clr  = flush | w_skid_mv;

    pipe_slot #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_skid_load),
      .i_clr   (w_skid_clr),
      .i_d     (s_data),
      .o_valid (w_skid_valid),
      .o_q     (w_skid_q)
    );

    assign w_skid_nxt = w_skid_load |
                        (w_skid_valid & ~w_skid_mv);

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        r_s_ready <= 1'b1;
      else if (flush)
        r_s_ready <= 1'b1;
      else
        r_s_ready <= ~w_skid_nxt;
    end

    assign s_ready = r_s_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (stall_clr)
      r_stall_cnt <= '0;
    else if (w_main_valid & ~m_ready & (r_stall_cnt != CNT_MAX))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign m_valid   = w_main_valid;
  assign m_data    = w_main_q;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1/CNT_W=4 and SKID=0/CNT_W=16 copies
// share stimulus; each is scored against its own queue model.
module tb_pipe_stage_reg;

  localparam logic [31:0] RV_A = 32'h1000_0004;
  localparam logic [31:0] RV_B = 32'h0000_0BAD;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [31:0] s_data;
  logic        flush;
  logic        m_ready;
  logic        stall_clr;

  logic        a_s_ready, a_m_valid;
  logic [31:0] a_m_data;
  logic [3:0]  a_stall;
  logic        b_s_ready, b_m_valid;
  logic [31:0] b_m_data;
  logic [15:0] b_stall;

  int checks = 0;
  int errors = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int ca, cb;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .WIDTH(32), .RESET_VALUE(RV_A), .SKID(1), .CNT_W(4)
  ) dut_a (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(a_s_ready), .s_data(s_data),
    .flush(flush),
    .m_valid(a_m_valid), .m_ready(m_ready), .m_data(a_m_data),
    .stall_cnt(a_stall), .stall_clr(stall_clr)
  );

  pipe_stage_reg #(
    .WIDTH(32), .RESET_VALUE(RV_B), .SKID(0), .CNT_W(16)
  ) dut_b (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data),
    .flush(flush),
    .m_valid(b_m_valid), .m_ready(m_ready), .m_data(b_m_data),
    .stall_cnt(b_stall), .stall_clr(stall_clr)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [31:0] ea, eb;
    ea = (qa.size() > 0) ? qa[0] : RV_A;
    eb = (qb.size() > 0) ? qb[0] : RV_B;
    chk("a_m_valid", 32'(a_m_valid), 32'(qa.size() > 0));
    chk("a_m_data",  a_m_data, ea);
    chk("a_s_ready", 32'(a_s_ready), 32'(qa.size() < 2));
    chk("a_stall",   32'(a_stall), 32'(ca));
    chk("b_m_valid", 32'(b_m_valid), 32'(qb.size() > 0));
    chk("b_m_data",  b_m_data, eb);
    chk("b_s_ready", 32'(b_s_ready),
        32'(qb.size() == 0 || m_ready));
    chk("b_stall",   32'(b_stall), 32'(cb));
  endtask

  // One clock: decide transfers from pre-edge model state, apply at the
  // edge, then compare on the falling edge.
  task automatic cycle();
    bit acc_a, acc_b, pop_a, pop_b, st_a, st_b;
    acc_a = s_valid && qa.size() < 2 && !flush;
    acc_b = s_valid && (qb.size() == 0 || m_ready) && !flush;
    pop_a = qa.size() > 0 && m_ready;
    pop_b = qb.size() > 0 && m_ready;
    st_a  = qa.size() > 0 && !m_ready;
    st_b  = qb.size() > 0 && !m_ready;
    @(posedge clk);
    if (rst) begin
      qa.delete(); qb.delete();
      ca = 0; cb = 0;
    end else begin
      if (flush) begin
        qa.delete(); qb.delete();
      end else begin
        if (pop_a) void'(qa.pop_front());
        if (acc_a) qa.push_back(s_data);
        if (pop_b) void'(qb.pop_front());
        if (acc_b) qb.push_back(s_data);
      end
      if (stall_clr) ca = 0;
      else if (st_a && ca < 15) ca++;
      if (stall_clr) cb = 0;
      else if (st_b && cb < 65535) cb++;
    end
    @(negedge clk);
    compare();
  endtask

  task automatic drive(bit v, logic [31:0] d, bit r, bit f, bit c);
    s_valid = v; s_data = d; m_ready = r; flush = f; stall_clr = c;
  endtask

  initial begin
    ca = 0; cb = 0;
    rst = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    cycle();
    cycle();
    chk("rst_m_valid", 32'(a_m_valid), 32'd0);
    chk("rst_m_data",  a_m_data, 32'h1000_0004);
    chk("rst_s_ready", 32'(a_s_ready), 32'd1);
    chk("rst_stall",   32'(a_stall), 32'd0);

    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
      cycle();
      chk("stream_a", a_m_data, 32'(i));
      chk("stream_b", b_m_data, 32'(i));
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle();
    chk("drain_a", 32'(a_m_valid), 32'd0);

    drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
    cycle();
    cycle();
    chk("bp_main",  a_m_data, 32'hA);
    chk("bp_ready", 32'(a_s_ready), 32'd0);
    chk("bp_stall", 32'(a_stall), 32'd3);
    drive(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
    cycle();
    chk("bp_out_b", a_m_data, 32'hB);
    cycle();
    chk("bp_out_c", a_m_data, 32'hC);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle();
    chk("bp_stall_hold", 32'(a_stall), 32'd3);

    drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h33, 1'b0, 1'b1, 1'b0);
    cycle();
    chk("fl_valid", 32'(a_m_valid), 32'd0);
    chk("fl_data",  a_m_data, 32'h1000_0004);
    chk("fl_ready", 32'(a_s_ready), 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("fl_empty", 32'(a_m_valid), 32'd0);
    end

    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle();
    drive(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle();
    chk("cnt_sat", 32'(a_stall), 32'd15);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle();
    chk("cnt_clr", 32'(a_stall), 32'd0);

    for (int i = 0; i < 10000; i++) begin
      drive(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0,
            ($urandom % 32) == 0, ($urandom % 64) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that generalises the fixed per-signal stage flops between CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB) into one block. It carries a packed payload of any width with a valid/ready handshake, synchronous flush, and an optional skid entry that registers the upstream ready. A saturating stall counter exposes back-pressure for performance analysis. Each stage boundary in the core instantiates one copy with the concatenated stage fields as payload.

## Interface
- WIDTH, 32: payload width in bits (≥1).
- RESET_VALUE, 0: payload value after reset and in every bubble, WIDTH bits (e.g. RESET_PC + 4 for a PC field).
- SKID, 1: 0 = single entry with combinational s_ready; 1 = two entries with registered s_ready.
- CNT_W, 16: stall counter width.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  upstream payload valid.
- s_ready  out  1  stage can accept this cycle.
- s_data  in  WIDTH  upstream payload.
- flush  in  1  synchronous kill of all held entries and of the current input.
- m_valid  out  1  downstream payload valid.
- m_ready  in  1  downstream accepts.
- m_data  out  WIDTH  downstream payload.
- stall_cnt  out  CNT_W  cycles with m_valid=1 and m_ready=0, saturating.
- stall_clr  in  1  synchronous clear of stall_cnt.

## Operation
- Transfer in: s_valid && s_ready at a rising edge. Transfer out: m_valid && m_ready.
- SKID=0: one entry. s_ready = !m_valid || m_ready (combinational). On input transfer the entry loads s_data and m_valid=1; on output-only transfer m_valid=0 and m_data=RESET_VALUE.
- SKID=1: main entry drives m_*; skid entry holds one extra word. s_ready is a flop, equal to !skid_valid.
  - Input accepted while main empty or draining: goes to main.
  - Input accepted while main full and m_ready=0: goes to skid; s_ready drops next cycle.
  - Main drains with skid full: skid moves to main, skid empties, s_ready rises next cycle.
  - Order preserved; no word dropped or duplicated.
- flush=1: at the edge all valid bits clear, all payload regs load RESET_VALUE, the input word that cycle is discarded even if s_valid && s_ready, and s_ready=1 next cycle. flush overrides every other update.
- Bubble: m_valid=0 always implies m_data=RESET_VALUE.
- stall_cnt increments when m_valid && !m_ready, holds at 2^CNT_W−1, and clears on stall_clr (clear wins over increment). flush does not affect stall_cnt.

## Timing
- Reset (async assert, state held while rst=1): m_valid=0, m_data=RESET_VALUE, skid empty, s_ready=1 (both modes), stall_cnt=0.
- Latency: input transfer at edge N gives m_valid=1 with that data after edge N (visible in cycle N+1).
- Throughput: one word per cycle when m_ready=1 continuously, both modes.
- SKID=1: no combinational path from m_ready to s_ready. SKID=0: one gate-level path.
- Simultaneous input and output transfer with main full, skid empty: main loads s_data, stays valid.
- Reset released mid-stream: first accepted word is the first s_valid at or after the first edge with rst=0.

## Structure
- Shared package pipe_pkg: default stage WIDTH constants per boundary (IF_ID_W, ID_EX_W, EX_MEM_W, MEM_WB_W) and RESET_PC.
- Sub-module pipe_slot: one WIDTH register with valid bit, load, and clear-to-RESET_VALUE; instantiated once (SKID=0) or twice (SKID=1).

## Test plan
- Reset: hold rst=1 with s_valid=1, s_data=0xDEADBEEF, RESET_VALUE=0x10000004 -> m_valid=0, m_data=0x10000004, s_ready=1, stall_cnt=0.
- Streaming: SKID=1, m_ready=1, send 0x1..0x8 back-to-back -> same order out, one per cycle, first one cycle after acceptance.
- Back-pressure: m_ready=0 and send 0xA, 0xB, 0xC -> 0xA in main, 0xB in skid, s_ready=0, 0xC held upstream. Raise m_ready -> out 0xA, 0xB, 0xC in order, stall_cnt equals stalled cycles.
- Flush: main=0x11, skid=0x22, s_valid=1 with 0x33, flush=1 -> next cycle m_valid=0, m_data=RESET_VALUE, s_ready=1, none of 0x11/0x22/0x33 ever appear.
- Counter: CNT_W=4, m_valid=1, m_ready=0 for 20 cycles -> stall_cnt=15. stall_clr pulse while still stalled -> 0 next cycle.
- Random valid/ready/flush, both SKID values, 10k cycles -> scoreboard match, bubbles show RESET_VALUE.
